// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
// -------------
// Turns a 4x8 single-port synchronous RAM (one write or one read per cycle,
// registered read data) into a 4-entry FIFO. Push and pop requests compete
// for the single RAM port. When both are eligible in the same cycle, the
// grant alternates using last_op.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  push request; hold in_valid/in_data until in_ready
//   in_data   push data
//   in_ready  push granted this cycle (combinational)
//   pop       pop request; hold until pop_ack
//   pop_ack   pop granted this cycle (combinational)
//   out_data  popped word, valid only while out_valid=1 (wired to ram_dout)
//   out_valid registered; high the cycle after a pop grant
//   full      count == DEPTH
//   empty     count == 0
//   count     occupancy, 0..DEPTH
//   ram_we    RAM write enable
//   ram_addr  RAM address
//   ram_din   RAM write data
//   ram_dout  RAM registered read data
module ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              pop,
  output logic              pop_ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              last_op;   // 1 = last granted op was a write
  logic              can_wr;
  logic              can_rd;
  logic              grant_wr;
  logic              grant_rd;

  // Eligibility and round-robin arbitration. Requests are masked by rst_n
  // so that nothing is granted, and the RAM is never written, while reset
  // is held. On contention the side that did not win last time gets the
  // port.
  always_comb begin
    full     = (count == DEPTH_C);
    empty    = (count == '0);
    can_wr   = rst_n & in_valid & ~full;
    can_rd   = rst_n & pop & ~empty;
    grant_wr = can_wr & (~can_rd | ~last_op);
    grant_rd = can_rd & (~can_wr | last_op);
  end

  // RAM port drive. When the port is not writing it always reads at rd_ptr.
  // On idle cycles the resulting dout change is harmless because out_valid
  // stays low.
  always_comb begin
    in_ready = grant_wr;
    pop_ack  = grant_rd;
    ram_we   = grant_wr;
    ram_addr = grant_wr ? wr_ptr : rd_ptr;
    ram_din  = in_data;
  end

  // The RAM output is already registered, so popped data is taken straight
  // from it.
  assign out_data = ram_dout;

  // Pointer, occupancy and arbitration history. At most one grant fires per
  // cycle, so count moves by at most one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_op   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= grant_rd;
      if (grant_wr) begin
        wr_ptr  <= wr_ptr + 1'b1;
        count   <= count + 1'b1;
        last_op <= 1'b1;
      end else if (grant_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        count   <= count - 1'b1;
        last_op <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl
// ----------------
// Directed bench for ram_fifo_ctrl. It includes a behavioural 4x8
// single-port RAM with registered read data, and compares the DUT outputs
// against hand-computed values.
module tb_ram_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       pop;
  logic       pop_ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       ram_we;
  logic [1:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  logic [7:0] mem [4];

  int checkCount = 0;
  int passCount  = 0;

  ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(2), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .pop      (pop),
    .pop_ack  (pop_ack),
    .out_data (out_data),
    .out_valid(out_valid),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: each cycle it either writes or performs a registered read.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_dout      <= mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Drive the request inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic p);
    in_valid = v;
    in_data  = d;
    pop      = p;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    stepClock();
    rst_n = 1'b1;
    #1;
  endtask

  logic [7:0] fillData [4];
  logic [1:0] wrapAddr [6];
  logic       contW    [4];
  logic [7:0] contPush [2];
  logic [7:0] contPop  [2];

  initial begin
    int wi;
    int ri;
    fillData = '{8'h11, 8'h22, 8'h33, 8'h44};
    wrapAddr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    contW    = '{1'b1, 1'b0, 1'b1, 1'b0};
    contPush = '{8'hB1, 8'hB2};
    contPop  = '{8'hA2, 8'hA3};

    // Reset with both requests active: nothing may be granted.
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'h99, 1'b1);
    stepClock();
    checkOutput("rst ram_we",    ram_we,    0);
    checkOutput("rst in_ready",  in_ready,  0);
    checkOutput("rst pop_ack",   pop_ack,   0);
    checkOutput("rst empty",     empty,     1);
    checkOutput("rst full",      full,      0);
    checkOutput("rst count",     count,     0);
    checkOutput("rst out_valid", out_valid, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    #1;

    // Fill the FIFO.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fillData[i], 1'b0);
      checkOutput($sformatf("fill%0d in_ready", i), in_ready, 1);
      checkOutput($sformatf("fill%0d ram_we", i),   ram_we,   1);
      checkOutput($sformatf("fill%0d ram_addr", i), ram_addr, i);
      checkOutput($sformatf("fill%0d ram_din", i),  ram_din,  fillData[i]);
      stepClock();
    end
    checkOutput("fill count", count, 4);
    checkOutput("fill full",  full,  1);
    checkOutput("fill empty", empty, 0);
    applyStimulus(1'b1, 8'h55, 1'b0);
    checkOutput("full push in_ready", in_ready, 0);
    checkOutput("full push ram_we",   ram_we,   0);
    stepClock();
    checkOutput("full push count", count, 4);

    // Drain: each pop_ack is followed by out_valid with the next word.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("drain%0d pop_ack", i),  pop_ack,  1);
      checkOutput($sformatf("drain%0d ram_we", i),   ram_we,   0);
      checkOutput($sformatf("drain%0d ram_addr", i), ram_addr, i);
      stepClock();
      checkOutput($sformatf("drain%0d out_valid", i), out_valid, 1);
      checkOutput($sformatf("drain%0d out_data", i),  out_data,  fillData[i]);
      checkOutput($sformatf("drain%0d count", i),     count,     3 - i);
    end
    checkOutput("drain empty", empty, 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("empty pop_ack", pop_ack, 0);
    stepClock();
    checkOutput("empty out_valid", out_valid, 0);
    checkOutput("empty count",     count,     0);

    // Contention: start from reset, push A1..A3, pop once so that last_op=0
    // and count=2, then hold both requests for 4 cycles.
    doReset();
    applyStimulus(1'b1, 8'hA1, 1'b0); stepClock();
    applyStimulus(1'b1, 8'hA2, 1'b0); stepClock();
    applyStimulus(1'b1, 8'hA3, 1'b0); stepClock();
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("pre-cont pop_ack", pop_ack, 1);
    stepClock();
    checkOutput("pre-cont out_data", out_data, 8'hA1);
    checkOutput("pre-cont count",    count,    2);
    wi = 0;
    ri = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, contPush[wi], 1'b1);
      checkOutput($sformatf("cont%0d in_ready", i), in_ready, contW[i]);
      checkOutput($sformatf("cont%0d pop_ack", i),  pop_ack,  !contW[i]);
      checkOutput($sformatf("cont%0d count", i),    count,    (i % 2 == 0) ? 2 : 3);
      stepClock();
      if (contW[i]) begin
        checkOutput($sformatf("cont%0d out_valid", i), out_valid, 0);
        wi++;
      end else begin
        checkOutput($sformatf("cont%0d out_valid", i), out_valid, 1);
        checkOutput($sformatf("cont%0d out_data", i),  out_data,  contPop[ri]);
        ri++;
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    stepClock();
    checkOutput("cont tail0 out_data", out_data, 8'hB1);
    stepClock();
    checkOutput("cont tail1 out_data", out_data, 8'hB2);
    checkOutput("cont tail count",     count,    0);

    // Wrap: six alternating push/pop pairs starting from pointer 0.
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0);
      checkOutput($sformatf("wrap%0d wr addr", i), ram_addr, wrapAddr[i]);
      checkOutput($sformatf("wrap%0d ram_we", i),  ram_we,   1);
      if (i > 0) begin
        checkOutput($sformatf("wrap%0d out_valid", i), out_valid, 1);
        checkOutput($sformatf("wrap%0d out_data", i),  out_data,  8'hC0 + 8'(i - 1));
      end
      stepClock();
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("wrap%0d pop_ack", i), pop_ack,  1);
      checkOutput($sformatf("wrap%0d rd addr", i), ram_addr, wrapAddr[i]);
      stepClock();
    end
    checkOutput("wrap last out_valid", out_valid, 1);
    checkOutput("wrap last out_data",  out_data,  8'hC5);
    checkOutput("wrap count",          count,     0);

    // Mid-operation reset while a pop is granted with count=3.
    applyStimulus(1'b1, 8'hD0, 1'b0); stepClock();
    applyStimulus(1'b1, 8'hD1, 1'b0); stepClock();
    applyStimulus(1'b1, 8'hD2, 1'b0); stepClock();
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("midrst count pre",   count,   3);
    checkOutput("midrst pop_ack pre", pop_ack, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst pop_ack", pop_ack, 0);
    checkOutput("midrst count",   count,   0);
    stepClock();
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("midrst out_valid", out_valid, 0);
    checkOutput("midrst count post", count,    0);
    checkOutput("midrst empty",      empty,    1);
    applyStimulus(1'b1, 8'hA5, 1'b0);
    checkOutput("post-rst wr addr", ram_addr, 0);
    checkOutput("post-rst ram_we",  ram_we,   1);
    stepClock();
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("post-rst pop_ack", pop_ack,  1);
    checkOutput("post-rst rd addr", ram_addr, 0);
    stepClock();
    checkOutput("post-rst out_valid", out_valid, 1);
    checkOutput("post-rst out_data",  out_data,  8'hA5);
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
